// File: rtl/ld_st_serializer.sv
// ld_st_serializer
//   Parallel-in, serial-out transmitter that feeds the serial input of a
//   load/store register chain. A word is captured on an accepted load and is
//   then shifted out one bit per valid/ready transfer. serLast marks the final
//   bit, and a one-cycle done pulse follows before the next word is accepted.
//
// Parameters
//   WIDTH     word width in bits (2..32)
//   LSB_FIRST 0 = MSB shifted out first, 1 = LSB shifted out first
//
// Ports
//   clk      rising-edge clock
//   clr      asynchronous active-low reset
//   ld       load request, sampled only while ready=1
//   dataIn   parallel word, captured on an accepted load
//   ready    idle, a load is accepted this cycle
//   serOut   current serial bit, 0 while serValid=0
//   serValid serOut holds a valid bit
//   serReady downstream accepts the bit this cycle
//   serLast  current bit is the last bit of the word
//   done     one-cycle pulse after the last bit transfers
module ld_st_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] dataIn,
  output logic             ready,
  output logic             serOut,
  output logic             serValid,
  input  logic             serReady,
  output logic             serLast,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

  stateT            state, stateNext;
  logic [WIDTH-1:0] shiftReg, shiftNext;
  logic [CW-1:0]    cnt, cntNext;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      shiftReg <= '0;
      cnt      <= '0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      cnt      <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    shiftNext = shiftReg;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (ld) begin
          shiftNext = dataIn;
          cntNext   = CW'(WIDTH - 1);
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (serReady) begin
          if (cnt == '0) begin
            stateNext = DONE;
          end else begin
            // Move toward the output end with zero fill.
            shiftNext = LSB_FIRST ? (shiftReg >> 1) : (shiftReg << 1);
            cntNext   = cnt - CW'(1);
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Every output decodes registered state only, so an asynchronous clear
  // drops serValid at once and no path exists from ld/serReady to outputs.
  always_comb begin
    ready    = (state == IDLE);
    serValid = (state == SHIFT);
    done     = (state == DONE);
    serOut   = serValid & (LSB_FIRST ? shiftReg[0] : shiftReg[WIDTH-1]);
    serLast  = serValid & (cnt == '0);
  end

endmodule
